io_port_controller: RTL and testbench

Sequences IN/OUT instructions from the memory stage onto the IO port latch block. It generates the IOE/IOR/IOW strobes and handshakes with the external device (in_valid / out_ack). It stalls the pipeline until each transfer completes or times out. It sits between the memory stage, the hazard/stall logic and the IO port latch.

---
 rtl/io_port_controller.sv | 194 +++++++++++++++++++
 tb/tb_io_port_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_controller.sv
// io_port_controller
// Steps IN/OUT instructions from the memory stage onto the IO port latch. It
// drives the IOE/IOR/IOW strobes and handshakes with the external device. The
// pipeline stays stalled until each transfer completes or times out.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   io_read_req       IN instruction in memory stage (held while stall=1)
//   io_write_req      OUT instruction in memory stage (held while stall=1)
//   wr_data           OUT data from the memory stage
//   in_valid          device presents valid data on PORTIN
//   out_ack           device has consumed PORTOUT
//   io_result         registered copy of wr_data for the latch Result input
//   IOE / IOR / IOW   latch enable, read strobe, write strobe
//   out_strobe        PORTOUT holds new data (waiting for out_ack)
//   stall             freezes IF..MEM (combinational, follows the requests in IDLE)
//   io_done           one-cycle completion pulse
//   io_timeout        accompanies io_done when a handshake timed out
//   busy              controller is not idle
module io_port_controller #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  io_read_req,
    input  logic                  io_write_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  in_valid,
    input  logic                  out_ack,
    output logic [DATA_WIDTH-1:0] io_result,
    output logic                  IOE,
    output logic                  IOR,
    output logic                  IOW,
    output logic                  out_strobe,
    output logic                  stall,
    output logic                  io_done,
    output logic                  io_timeout,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_RD_WAIT     = 3'd1,
        S_RD_CAPTURE  = 3'd2,
        S_WR_DRIVE    = 3'd3,
        S_WR_WAIT_ACK = 3'd4,
        S_DONE        = 3'd5
    } state_e;

    // Last counter value before the handshake wait gives up.
    localparam logic                 TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST   =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic                  pending_q, pending_d;   // read queued behind a write
    logic                  tflag_q, tflag_d;       // sticky timeout across legs
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic ioe_q, ioe_d;
    logic ior_q, ior_d;
    logic iow_q, iow_d;
    logic ostr_q, ostr_d;
    logic done_q, done_d;
    logic tout_q, tout_d;
    logic busy_q, busy_d;

    logic expired;

    // Next-state logic and next values of the registered Moore outputs.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        tflag_d   = tflag_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        expired   = TIMEOUT_EN && (cnt_q == CNT_LAST);

        case (state_q)
            S_IDLE: begin
                pending_d = 1'b0;
                if (io_write_req) begin
                    // Write goes first; a simultaneous read is queued.
                    result_d  = wr_data;
                    pending_d = io_read_req;
                    tflag_d   = 1'b0;
                    state_d   = S_WR_DRIVE;
                end else if (io_read_req) begin
                    tflag_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                // Handshake wins over an expiring counter.
                if (in_valid) begin
                    state_d = S_RD_CAPTURE;
                end else if (expired) begin
                    tflag_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_RD_CAPTURE: begin
                state_d = S_DONE;
            end
            S_WR_DRIVE: begin
                cnt_d   = '0;
                state_d = S_WR_WAIT_ACK;
            end
            S_WR_WAIT_ACK: begin
                if (out_ack) begin
                    state_d = S_DONE;
                end else if (expired) begin
                    tflag_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_DONE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_RD_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with it.
        ioe_d  = (state_d == S_RD_CAPTURE) || (state_d == S_WR_DRIVE);
        ior_d  = (state_d == S_RD_CAPTURE);
        iow_d  = (state_d == S_WR_DRIVE);
        ostr_d = (state_d == S_WR_WAIT_ACK);
        done_d = (state_d == S_DONE) && !pending_d;
        tout_d = done_d && tflag_d;
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            tflag_q   <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
            ioe_q     <= 1'b0;
            ior_q     <= 1'b0;
            iow_q     <= 1'b0;
            ostr_q    <= 1'b0;
            done_q    <= 1'b0;
            tout_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            tflag_q   <= tflag_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            ioe_q     <= ioe_d;
            ior_q     <= ior_d;
            iow_q     <= iow_d;
            ostr_q    <= ostr_d;
            done_q    <= done_d;
            tout_q    <= tout_d;
            busy_q    <= busy_d;
        end
    end

    // Stall must react to a request in IDLE in the same cycle.
    assign stall = ((state_q != S_IDLE) && (state_q != S_DONE))
                || ((state_q == S_IDLE) && (io_read_req || io_write_req))
                || ((state_q == S_DONE) && pending_q);

    assign io_result  = result_q;
    assign IOE        = ioe_q;
    assign IOR        = ior_q;
    assign IOW        = iow_q;
    assign out_strobe = ostr_q;
    assign io_done    = done_q;
    assign io_timeout = tout_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_io_port_controller.sv
// Testbench for io_port_controller: three instances (timeouts 255, 4, 2) share
// stimulus; a small model of the IO port latch records PORTOUT and IN.
module tb_io_port_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, rd, wr, iv, ack;
    logic [15:0] wd, portin;

    logic [15:0] res_w [3];
    logic [2:0]  ioe_w, ior_w, iow_w, ostr_w, stall_w, done_w, to_w, busy_w;

    io_port_controller #(.DATA_WIDTH(16), .TIMEOUT_CYCLES(255), .CNT_WIDTH(8)) u_dut0 (
        .clk(clk), .reset(reset), .io_read_req(rd), .io_write_req(wr), .wr_data(wd),
        .in_valid(iv), .out_ack(ack), .io_result(res_w[0]), .IOE(ioe_w[0]), .IOR(ior_w[0]),
        .IOW(iow_w[0]), .out_strobe(ostr_w[0]), .stall(stall_w[0]), .io_done(done_w[0]),
        .io_timeout(to_w[0]), .busy(busy_w[0]));

    io_port_controller #(.DATA_WIDTH(16), .TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) u_dut4 (
        .clk(clk), .reset(reset), .io_read_req(rd), .io_write_req(wr), .wr_data(wd),
        .in_valid(iv), .out_ack(ack), .io_result(res_w[1]), .IOE(ioe_w[1]), .IOR(ior_w[1]),
        .IOW(iow_w[1]), .out_strobe(ostr_w[1]), .stall(stall_w[1]), .io_done(done_w[1]),
        .io_timeout(to_w[1]), .busy(busy_w[1]));

    io_port_controller #(.DATA_WIDTH(16), .TIMEOUT_CYCLES(2), .CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .io_read_req(rd), .io_write_req(wr), .wr_data(wd),
        .in_valid(iv), .out_ack(ack), .io_result(res_w[2]), .IOE(ioe_w[2]), .IOR(ior_w[2]),
        .IOW(iow_w[2]), .out_strobe(ostr_w[2]), .stall(stall_w[2]), .io_done(done_w[2]),
        .io_timeout(to_w[2]), .busy(busy_w[2]));

    // IO port latch model (not affected by the controller reset).
    logic [15:0] portout_m [3];
    logic [15:0] in_m [3];
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ioe_w[k] && iow_w[k]) portout_m[k] <= res_w[k];
            if (ioe_w[k] && ior_w[k]) in_m[k] <= portin;
        end
    end

    int total = 0;
    int bad   = 0;

    // {IOE, IOR, IOW, out_strobe, stall, io_done, io_timeout, busy}
    function automatic logic [7:0] outs(input int k);
        return {ioe_w[k], ior_w[k], iow_w[k], ostr_w[k], stall_w[k], done_w[k], to_w[k], busy_w[k]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rd = 1'b0; wr = 1'b0; iv = 1'b0; ack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Entered in c0 with requests already driven; returns at the io_done cycle.
    task automatic run_until_done(input int k, output int n, output int ostr_n,
                                  output int ior_n, output int iow_n, output logic tout);
        logic found;
        found = 1'b0; n = -1; ostr_n = 0; ior_n = 0; iow_n = 0; tout = 1'b0;
        for (int c = 0; c < 40; c++) begin
            sample();
            ostr_n += int'(ostr_w[k]);
            ior_n  += int'(ior_w[k]);
            iow_n  += int'(iow_w[k]);
            if (done_w[k]) begin
                tout  = to_w[k];
                n     = c;
                found = 1'b1;
                break;
            end
            step();
        end
        if (!found) check($sformatf("wait_done_dut%0d", k), 32'd0, 32'd1);
    endtask

    typedef struct {
        logic        rd, wr;
        logic [15:0] wd;
        logic        iv, ack;
        logic [15:0] pin;
        logic [7:0]  exp_o;
        logic [15:0] exp_res;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic w, input logic [15:0] d,
                                input logic v, input logic a, input logic [15:0] p,
                                input logic [7:0] eo, input logic [15:0] er);
        vec_t t;
        t.rd = r; t.wr = w; t.wd = d; t.iv = v; t.ack = a; t.pin = p;
        t.exp_o = eo; t.exp_res = er;
        return t;
    endfunction

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vt [18];
        int   n, on, rn, wn, dcnt;
        logic tf;

        // Read, in_valid high from the start, PORTIN=A5A5.
        vt[0]  = mk(1, 0, 16'h0000, 1, 0, 16'hA5A5, 8'b0000_1000, 16'h0000);
        vt[1]  = mk(1, 0, 16'h0000, 1, 0, 16'hA5A5, 8'b0000_1001, 16'h0000);
        vt[2]  = mk(1, 0, 16'h0000, 1, 0, 16'hA5A5, 8'b1100_1001, 16'h0000);
        vt[3]  = mk(1, 0, 16'h0000, 1, 0, 16'hA5A5, 8'b0000_0101, 16'h0000);
        vt[4]  = mk(0, 0, 16'h0000, 0, 0, 16'hA5A5, 8'b0000_0000, 16'h0000);
        // Write, immediate ack.
        vt[5]  = mk(0, 1, 16'h1234, 0, 0, 16'h0000, 8'b0000_1000, 16'h0000);
        vt[6]  = mk(0, 1, 16'h1234, 0, 0, 16'h0000, 8'b1010_1001, 16'h1234);
        vt[7]  = mk(0, 1, 16'h1234, 0, 1, 16'h0000, 8'b0001_1001, 16'h1234);
        vt[8]  = mk(0, 1, 16'h1234, 0, 1, 16'h0000, 8'b0000_0101, 16'h1234);
        vt[9]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 8'b0000_0000, 16'h1234);
        // Simultaneous read + write: write leg, stalled DONE, read leg, one io_done.
        vt[10] = mk(1, 1, 16'h00FF, 1, 1, 16'hBEEF, 8'b0000_1000, 16'h1234);
        vt[11] = mk(1, 1, 16'h00FF, 1, 1, 16'hBEEF, 8'b1010_1001, 16'h00FF);
        vt[12] = mk(1, 1, 16'h00FF, 1, 1, 16'hBEEF, 8'b0001_1001, 16'h00FF);
        vt[13] = mk(1, 1, 16'h00FF, 1, 1, 16'hBEEF, 8'b0000_1001, 16'h00FF);
        vt[14] = mk(1, 1, 16'h00FF, 1, 1, 16'hBEEF, 8'b0000_1001, 16'h00FF);
        vt[15] = mk(1, 1, 16'h00FF, 1, 1, 16'hBEEF, 8'b1100_1001, 16'h00FF);
        vt[16] = mk(1, 1, 16'h00FF, 1, 1, 16'hBEEF, 8'b0000_0101, 16'h00FF);
        vt[17] = mk(0, 0, 16'h0000, 0, 0, 16'hBEEF, 8'b0000_0000, 16'h00FF);

        // Reset state of all instances.
        reset = 1'b1; idle_inputs(); wd = '0; portin = '0;
        step(); step();
        reset = 1'b0;
        sample();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_outs_dut%0d", k), 32'(outs(k)), 32'd0);
            check($sformatf("reset_result_dut%0d", k), 32'(res_w[k]), 32'd0);
        end
        step();

        // Table-driven cycle vectors on the 255-cycle instance.
        for (int i = 0; i < 18; i++) begin
            rd = vt[i].rd; wr = vt[i].wr; wd = vt[i].wd;
            iv = vt[i].iv; ack = vt[i].ack; portin = vt[i].pin;
            sample();
            check($sformatf("vec%0d_outs", i), 32'(outs(0)), 32'(vt[i].exp_o));
            check($sformatf("vec%0d_result", i), 32'(res_w[0]), 32'(vt[i].exp_res));
            if (i == 4) check("read_in_value", 32'(in_m[0]), 32'h0000_A5A5);
            if (i == 7) check("write_portout", 32'(portout_m[0]), 32'h0000_1234);
            step();
        end
        check("rw_portout", 32'(portout_m[0]), 32'h0000_00FF);
        check("rw_in_value", 32'(in_m[0]), 32'h0000_BEEF);

        // Write with ack 5 cycles after out_strobe rises.
        do_reset();
        wr = 1'b1; wd = 16'h1234;
        sample();
        check("slow_wr_c0_outs", 32'(outs(0)), 32'b0000_1000);
        step(); sample();
        check("slow_wr_c1_outs", 32'(outs(0)), 32'b1010_1001);
        step(); sample();
        check("slow_wr_portout", 32'(portout_m[0]), 32'h0000_1234);
        on = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step();
            ack = (c == 5);
            sample();
            on += int'(ostr_w[0]);
        end
        step(); sample();
        check("slow_wr_strobe_cycles", 32'(on), 32'd6);
        check("slow_wr_done_outs", 32'(outs(0)), 32'b0000_0101);
        idle_inputs();
        step(); sample();
        check("slow_wr_idle", 32'(outs(0)), 32'd0);

        // Read timeout, TIMEOUT_CYCLES=4: 4 RD_WAIT cycles, no IOR, IN unchanged.
        do_reset();
        portin = 16'hDEAD; rd = 1'b1;
        run_until_done(1, n, on, rn, wn, tf);
        check("rd_to_latency", 32'(n), 32'd5);
        check("rd_to_flag", 32'(tf), 32'd1);
        check("rd_to_ior_count", 32'(rn), 32'd0);
        idle_inputs();
        step(); sample();
        check("rd_to_in_unchanged", 32'(in_m[1]), 32'h0000_BEEF);
        check("rd_to_idle", 32'(outs(1)), 32'd0);

        // Write timeout, TIMEOUT_CYCLES=4: PORTOUT still updated.
        do_reset();
        wr = 1'b1; wd = 16'h0A0A;
        run_until_done(1, n, on, rn, wn, tf);
        check("wr_to_latency", 32'(n), 32'd6);
        check("wr_to_flag", 32'(tf), 32'd1);
        check("wr_to_strobe_cycles", 32'(on), 32'd4);
        check("wr_to_iow_count", 32'(wn), 32'd1);
        idle_inputs();
        step(); sample();
        check("wr_to_portout", 32'(portout_m[1]), 32'h0000_0A0A);

        // Reset while waiting for out_ack aborts the write.
        do_reset();
        wr = 1'b1; wd = 16'h5555;
        sample(); step(); step(); sample();
        check("abort_in_wait", 32'(ostr_w[0]), 32'd1);
        reset = 1'b1; wr = 1'b0; ack = 1'b1; iv = 1'b1;
        step();
        reset = 1'b0; ack = 1'b0; iv = 1'b0;
        sample();
        check("abort_outs", 32'(outs(0)), 32'd0);
        check("abort_result", 32'(res_w[0]), 32'd0);
        dcnt = 0;
        for (int c = 0; c < 3; c++) begin
            step(); sample();
            dcnt += int'(done_w[0]);
        end
        check("abort_no_done", 32'(dcnt), 32'd0);
        step();
        portin = 16'h1357; rd = 1'b1; iv = 1'b1;
        run_until_done(0, n, on, rn, wn, tf);
        check("post_abort_rd_latency", 32'(n), 32'd3);
        check("post_abort_rd_ior", 32'(rn), 32'd1);
        check("post_abort_rd_flag", 32'(tf), 32'd0);
        idle_inputs();
        step(); sample();
        check("post_abort_rd_in", 32'(in_m[0]), 32'h0000_1357);

        // in_valid arrives in the expiry cycle, TIMEOUT_CYCLES=2: capture wins.
        do_reset();
        portin = 16'h2468; rd = 1'b1; iv = 1'b0;
        sample(); step(); sample();
        check("race_c1_outs", 32'(outs(2)), 32'b0000_1001);
        step(); iv = 1'b1; sample();
        check("race_c2_outs", 32'(outs(2)), 32'b0000_1001);
        step(); sample();
        check("race_c3_outs", 32'(outs(2)), 32'b1100_1001);
        step(); sample();
        check("race_c4_outs", 32'(outs(2)), 32'b0000_0101);
        idle_inputs();
        step(); sample();
        check("race_in_value", 32'(in_m[2]), 32'h0000_2468);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
